// File: rtl/pipelined_multiplier_if.sv
// Operand issue / result writeback bundle for pipelined_multiplier.
// PIPELINED_MULTIPLIER_FLAGS_EN adds the registered {N,Z} flags signal.
interface pipelined_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [WIDTH-1:0]     d;
    logic [2:0]           op_type;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 err;
`ifdef PIPELINED_MULTIPLIER_FLAGS_EN
    logic [1:0]           flags;

    modport master (
        output in_valid, a, b, c, d, op_type, flush, out_ready,
        input  in_ready, out_valid, result, err, flags
    );

    modport slave (
        input  in_valid, a, b, c, d, op_type, flush, out_ready,
        output in_ready, out_valid, result, err, flags
    );
`else
    modport master (
        output in_valid, a, b, c, d, op_type, flush, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, a, b, c, d, op_type, flush, out_ready,
        output in_ready, out_valid, result, err
    );
`endif
endinterface

// File: rtl/pipelined_multiplier.sv
// Pipelined MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit, STAGES cycles issue-to-result (1..8).
// Define PIPELINED_MULTIPLIER_FLAGS_EN to add registered {N,Z} result flags.
module pipelined_multiplier #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    pipelined_multiplier_if.slave bus
);
    localparam int RW       = 2 * WIDTH;
    localparam int CALC_STG = (STAGES > 1) ? 1 : 0;
    localparam int NPAY     = STAGES - CALC_STG;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          err;
`ifdef PIPELINED_MULTIPLIER_FLAGS_EN
        logic [1:0]    flags;
`endif
    } payload_t;

    function automatic payload_t mul_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op
    );
        logic [RW-1:0] prod_u;
        logic [RW-1:0] prod_s;
        logic [RW-1:0] acc;
        payload_t      p;
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        acc    = {c, d};
        p      = '0;
        case (op)
            3'b000:  p.res = {{WIDTH{1'b0}}, prod_u[WIDTH-1:0]};
            3'b001:  p.res = {{WIDTH{1'b0}}, prod_u[WIDTH-1:0] + c};
            3'b100:  p.res = prod_u;
            3'b101:  p.res = prod_u + acc;
            3'b110:  p.res = prod_s;
            3'b111:  p.res = prod_s + acc;
            default: p.err = 1'b1;
        endcase
`ifdef PIPELINED_MULTIPLIER_FLAGS_EN
        // Short forms only define the low word, so flags look at that half.
        if (!p.err) begin
            if (op[2]) p.flags = {p.res[RW-1], (p.res == '0)};
            else       p.flags = {p.res[WIDTH-1], (p.res[WIDTH-1:0] == '0)};
        end
`endif
        return p;
    endfunction

    logic              stall;
    logic              accept;
    logic [STAGES-1:0] vld_q;
    payload_t          calc;
    payload_t          pay_q [NPAY];

    // A stall freezes every stage, bubbles included.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign accept       = bus.in_valid && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else if (bus.flush) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= accept;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign calc = mul_op(bus.a, bus.b, bus.c, bus.d, bus.op_type);
        end else begin : g_opreg
            // Operands land in stage 1; extension is chosen from the registered type.
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] c_q;
            logic [WIDTH-1:0] d_q;
            logic [2:0]       op_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    c_q  <= '0;
                    d_q  <= '0;
                    op_q <= '0;
                end else if (accept) begin
                    a_q  <= bus.a;
                    b_q  <= bus.b;
                    c_q  <= bus.c;
                    d_q  <= bus.d;
                    op_q <= bus.op_type;
                end
            end

            assign calc = mul_op(a_q, b_q, c_q, d_q, op_q);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPAY; i++) begin
                pay_q[i] <= '0;
            end
        end else if (!stall) begin
            pay_q[0] <= calc;
            for (int i = 1; i < NPAY; i++) begin
                pay_q[i] <= pay_q[i-1];
            end
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.result    = pay_q[NPAY-1].res;
    assign bus.err       = pay_q[NPAY-1].err;
`ifdef PIPELINED_MULTIPLIER_FLAGS_EN
    assign bus.flags     = pay_q[NPAY-1].flags;
`endif

endmodule
